// File: rtl/fa_pkg.sv
// Shared constants for the structural full adder slice.
`timescale 1ns / 1ps

package fa_pkg;

    // Propagation delay in ns applied to every gate primitive by default.
    localparam int unsigned GATE_DELAY_DEFAULT = 50;

    // Settling bounds of the combinational outputs relative to the last input change.
    localparam int unsigned SUM_SETTLE_GATES   = 2;
    localparam int unsigned CARRY_SETTLE_GATES = 3;

endpackage : fa_pkg

// File: rtl/structural_full_adder_half_adder.sv
// Gate-level half adder: s = x ^ y, c = x & y, one primitive level each.
`timescale 1ns / 1ps

module half_adder
    import fa_pkg::*;
#(
    parameter int unsigned GATE_DELAY = GATE_DELAY_DEFAULT
) (
    output wire  s,
    output wire  c,
    input  logic x,
    input  logic y
);

    // Sum and carry primitives; X/Z on x or y propagates per primitive semantics.
    xor #(GATE_DELAY) u_xor (s, x, y);
    and #(GATE_DELAY) u_and (c, x, y);

endmodule : half_adder

// File: rtl/structural_full_adder.sv
// Full adder built from two half adders and an or gate, plus an optional
// enabled capture register with synchronous reset.
`timescale 1ns / 1ps

module structural_full_adder
    import fa_pkg::*;
#(
    parameter int unsigned GATE_DELAY = GATE_DELAY_DEFAULT
) (
    output wire  sum,
    output wire  carryout,
    input  logic a,
    input  logic b,
    input  logic carryin,
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sum_q,
    output logic carryout_q,
    output logic valid_q
);

    wire ab_sum;
    wire ab_carry;
    wire cin_carry;

    // First stage adds the two addends.
    half_adder #(
        .GATE_DELAY(GATE_DELAY)
    ) u_ha_ab (
        .s(ab_sum),
        .c(ab_carry),
        .x(a),
        .y(b)
    );

    // Second stage folds in the carry-in; its sum is the final sum.
    half_adder #(
        .GATE_DELAY(GATE_DELAY)
    ) u_ha_cin (
        .s(sum),
        .c(cin_carry),
        .x(ab_sum),
        .y(carryin)
    );

    // Either stage producing a carry yields the carry-out.
    or #(GATE_DELAY) u_or_carry (carryout, ab_carry, cin_carry);

    // Capture register: reset wins over enable, enable low holds the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q      <= 1'b0;
            carryout_q <= 1'b0;
            valid_q    <= 1'b0;
        end else if (en) begin
            sum_q      <= sum;
            carryout_q <= carryout;
            valid_q    <= 1'b1;
        end
    end

endmodule : structural_full_adder

// File: tb/tb_structural_full_adder.sv
// Directed bench for structural_full_adder: truth table, settle timing,
// capture/hold/reset behaviour of the registered stage and X handling.
`timescale 1ns / 1ps

module tb_structural_full_adder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic carryin = 1'b0;
    wire  sum;
    wire  carryout;
    logic sum_q;
    logic carryout_q;
    logic valid_q;

    int errors = 0;
    int checks = 0;

    structural_full_adder #(
        .GATE_DELAY(50)
    ) dut (
        .sum(sum),
        .carryout(carryout),
        .a(a),
        .b(b),
        .carryin(carryin),
        .clk(clk),
        .reset(reset),
        .en(en),
        .sum_q(sum_q),
        .carryout_q(carryout_q),
        .valid_q(valid_q)
    );

    // 400 ns period so inputs set on a falling edge settle before the next rising edge.
    always #200 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic es, input logic ec, input logic ev);
        chk({tag, ".sum_q"}, sum_q, es);
        chk({tag, ".carryout_q"}, carryout_q, ec);
        chk({tag, ".valid_q"}, valid_q, ev);
    endtask

    // Vectors are {a,b,cin}; expectations are {sum,carryout}, computed by hand.
    logic [2:0] vec [8];
    logic [1:0] exp_sc [8];

    initial begin
        vec    = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111};
        exp_sc = '{2'b00,  2'b10,  2'b10,  2'b10,  2'b01,  2'b01,  2'b01,  2'b11};

        // Truth table, each vector held 200 ns and sampled at its end.
        for (int i = 0; i < 8; i++) begin
            {a, b, carryin} = vec[i];
            #200;
            chk($sformatf("tt%0d.sum", i), sum, exp_sc[i][1]);
            chk($sformatf("tt%0d.carryout", i), carryout, exp_sc[i][0]);
        end

        // Settling: step 000 -> 111, sum by 100 ns and carryout by 150 ns.
        {a, b, carryin} = 3'b000;
        #200;
        {a, b, carryin} = 3'b111;
        #100.5;
        chk("settle.sum", sum, 1'b1);
        #50;
        chk("settle.carryout", carryout, 1'b1);

        // Reset for one edge clears the registered stage.
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        chk_regs("reset", 1'b0, 1'b0, 1'b0);

        // Capture 111 one edge later.
        reset = 1'b0;
        en    = 1'b1;
        {a, b, carryin} = 3'b111;
        @(negedge clk);
        chk_regs("cap111", 1'b1, 1'b1, 1'b1);

        // Capture 110.
        {a, b, carryin} = 3'b110;
        @(negedge clk);
        chk_regs("cap110", 1'b0, 1'b1, 1'b1);

        // Hold for three edges while the combinational outputs follow 100.
        en = 1'b0;
        {a, b, carryin} = 3'b100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_regs($sformatf("hold%0d", k), 1'b0, 1'b1, 1'b1);
            chk($sformatf("hold%0d.sum", k), sum, 1'b1);
            chk($sformatf("hold%0d.carryout", k), carryout, 1'b0);
        end

        // Mid-cycle input wiggle with en low must not reach the registers.
        #50;
        {a, b, carryin} = 3'b111;
        #50;
        {a, b, carryin} = 3'b001;
        @(negedge clk);
        chk_regs("wiggle", 1'b0, 1'b1, 1'b1);

        // Reset beats enable at the same edge and discards the held result.
        reset = 1'b1;
        en    = 1'b1;
        {a, b, carryin} = 3'b111;
        @(negedge clk);
        chk_regs("rstprio", 1'b0, 1'b0, 1'b0);

        // After reset with enable low the cleared state holds.
        reset = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        chk_regs("posthold", 1'b0, 1'b0, 1'b0);

        // Capture 101 after reset.
        en = 1'b1;
        {a, b, carryin} = 3'b101;
        @(negedge clk);
        chk_regs("cap101", 1'b0, 1'b1, 1'b1);
        en = 1'b0;

        // Unknown addend with b=cin=0 cannot produce a carry.
        a       = 1'bx;
        b       = 1'b0;
        carryin = 1'b0;
        #200;
        chk("xprop.carryout", carryout, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_structural_full_adder
